// File: rtl/mem_loader_pkg.sv
// Shared loader definitions: state and error-code encodings,
// default data/address widths taken from the project macros.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif

package mem_loader_pkg;

   localparam int LDR_AW = `ADDR_WIDTH;
   localparam int LDR_RW = `REG_WIDTH;

   localparam logic [2:0] LDR_IDLE   = 3'd0;
   localparam logic [2:0] LDR_WRITE  = 3'd1;
   localparam logic [2:0] LDR_VERIFY = 3'd2;
   localparam logic [2:0] LDR_DONE   = 3'd3;
   localparam logic [2:0] LDR_ERROR  = 3'd4;

   localparam logic [1:0] LDR_ERR_NONE  = 2'd0;
   localparam logic [1:0] LDR_ERR_RANGE = 2'd1;
   localparam logic [1:0] LDR_ERR_CSUM  = 2'd2;

endpackage

// File: rtl/mem_loader_checksum.sv
// Modulo-2^W running byte sum with synchronous clear and enable.
// Ports: clk, reset_n, i_clr, i_en, i_data -> o_sum.
module ldr_checksum #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_sum
);

   logic [W-1:0] r_sum;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sum <= '0;
      end else if (i_clr) begin
         r_sum <= '0;
      end else if (i_en) begin
         r_sum <= r_sum + i_data;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/mem_loader.sv
// Memory image loader: streams bytes from a valid/ready source into
// mem, optionally reads the range back against a checksum, then
// releases the mem port and pulses run_pulse to start the fetcher.
// Ports: start/base_addr/length request; s_valid/s_data/s_ready
// source; mem_own/mem_we/mem_addr/mem_din/mem_dout mem port;
// busy/done/error/err_code/run_pulse status.
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = LDR_AW,
   parameter int REG_WIDTH  = LDR_RW,
   parameter int DEPTH      = 32,
   parameter int VERIFY     = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] length,
   input  logic                  s_valid,
   input  logic [REG_WIDTH-1:0]  s_data,
   output logic                  s_ready,
   output logic                  mem_own,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [REG_WIDTH-1:0]  mem_din,
   input  logic [REG_WIDTH-1:0]  mem_dout,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic                  run_pulse
);

   localparam logic [ADDR_WIDTH:0] L_DEPTH =
      (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] L_ONE =
      ADDR_WIDTH'(1);

   logic [2:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH-1:0] r_len;
   logic                  r_rd_vld;
   logic                  r_done;
   logic                  r_error;
   logic [1:0]            r_err_code;
   logic                  r_run;

   logic                  w_wr;
   logic                  w_vf;
   logic                  w_xfer;
   logic                  w_accept;
   logic                  w_range_bad;
   logic                  w_issue;
   logic [ADDR_WIDTH:0]   w_end;
   logic [REG_WIDTH-1:0]  w_wsum;
   logic [REG_WIDTH-1:0]  w_rsum;
   logic [REG_WIDTH-1:0]  w_rsum_nxt;

   assign w_wr   = (r_state == LDR_WRITE);
   assign w_vf   = (r_state == LDR_VERIFY);
   assign w_xfer = w_wr & s_valid;

   assign w_accept = start & ~(w_wr | w_vf);

   // Range sum is one bit wider so base+length cannot wrap.
   assign w_end = {1'b0, base_addr} + {1'b0, length};
   assign w_range_bad = (w_end > L_DEPTH);

   // The last verify cycle only consumes read data; no address.
   assign w_issue = w_wr | (w_vf & (r_cnt != '0));

   // Final read byte arrives in the compare cycle itself.
   assign w_rsum_nxt = w_rsum + mem_dout;

   assign s_ready   = w_wr;
   assign mem_own   = w_wr | w_vf;
   assign mem_we    = w_xfer;
   assign mem_addr  = w_issue ? r_ptr : '0;
   assign mem_din   = w_wr ? s_data : '0;
   assign busy      = w_wr | w_vf;
   assign done      = r_done;
   assign error     = r_error;
   assign err_code  = r_err_code;
   assign run_pulse = r_run;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= LDR_IDLE;
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_base     <= '0;
         r_len      <= '0;
         r_rd_vld   <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_err_code <= LDR_ERR_NONE;
         r_run      <= 1'b0;
      end else begin
         r_run <= 1'b0;
         if (w_accept) begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= LDR_ERR_NONE;
            if (w_range_bad) begin
               r_state    <= LDR_ERROR;
               r_error    <= 1'b1;
               r_err_code <= LDR_ERR_RANGE;
            end else if (length == '0) begin
               r_state <= LDR_DONE;
               r_done  <= 1'b1;
               r_run   <= 1'b1;
            end else begin
               r_state <= LDR_WRITE;
               r_ptr   <= base_addr;
               r_cnt   <= length;
               r_base  <= base_addr;
               r_len   <= length;
            end
         end else begin
            case (r_state)
               LDR_WRITE: begin
                  if (w_xfer) begin
                     if (r_cnt == L_ONE) begin
                        r_ptr    <= r_base;
                        r_cnt    <= r_len;
                        r_rd_vld <= 1'b0;
                        if (VERIFY != 0) begin
                           r_state <= LDR_VERIFY;
                        end else begin
                           r_state <= LDR_DONE;
                           r_done  <= 1'b1;
                           r_run   <= 1'b1;
                        end
                     end else begin
                        r_ptr <= r_ptr + L_ONE;
                        r_cnt <= r_cnt - L_ONE;
                     end
                  end
               end
               LDR_VERIFY: begin
                  r_rd_vld <= (r_cnt != '0);
                  if (r_cnt != '0) begin
                     r_ptr <= r_ptr + L_ONE;
                     r_cnt <= r_cnt - L_ONE;
                  end else if (w_rsum_nxt == w_wsum) begin
                     r_state <= LDR_DONE;
                     r_done  <= 1'b1;
                     r_run   <= 1'b1;
                  end else begin
                     r_state    <= LDR_ERROR;
                     r_error    <= 1'b1;
                     r_err_code <= LDR_ERR_CSUM;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   ldr_checksum #(.W(REG_WIDTH)) u_wsum (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_accept),
      .i_en    (w_xfer),
      .i_data  (s_data),
      .o_sum   (w_wsum)
   );

   ldr_checksum #(.W(REG_WIDTH)) u_rsum (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_accept),
      .i_en    (w_vf & r_rd_vld),
      .i_data  (mem_dout),
      .o_sum   (w_rsum)
   );

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: table of load scenarios plus
// hand-written reset-mid-write sequence, with a behavioural mem.
module tb_mem_loader;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [7:0] base_addr;
   logic [7:0] length;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       mem_own;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_din;
   logic [7:0] mem_dout;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] err_code;
   logic       run_pulse;

   int checks;
   int failures;

   logic [7:0] mem [32];
   logic       clr_mem;
   logic       fault_en;
   logic [7:0] fault_addr;

   mem_loader #(
      .ADDR_WIDTH (8),
      .REG_WIDTH  (8),
      .DEPTH      (32),
      .VERIFY     (1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .mem_own   (mem_own),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .err_code  (err_code),
      .run_pulse (run_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-read memory; optional stuck-low bit 0 at fault_addr.
   always @(posedge clk) begin
      logic [7:0] rd;
      rd = (mem_addr < 8'd32) ? mem[mem_addr[4:0]] : 8'h00;
      if (fault_en && mem_addr == fault_addr) rd = rd & 8'hFE;
      mem_dout <= rd;
      if (clr_mem) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      end else if (mem_we && mem_addr < 8'd32) begin
         mem[mem_addr[4:0]] <= mem_din;
      end
   end

   typedef struct {
      logic [7:0] base;
      logic [7:0] len;
      bit         stall;
      bit         fault;
      int         poke;
      bit         e_done;
      bit         e_err;
      int         e_code;
      int         e_wr;
      int         e_busy;
      int         e_run;
   } vec_t;

   vec_t tv[10];

   function automatic logic [7:0] bval(input int k);
      logic [7:0] t [4];
      t = '{8'hA9, 8'h05, 8'h85, 8'h10};
      if (k < 4) return t[k];
      return 8'(k * 13 + 7);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic clear_mem();
      @(negedge clk);
      clr_mem = 1'b1;
      @(negedge clk);
      clr_mem = 1'b0;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      int  idx, wr, bz, rn, webad, bad;
      bit  xfer, tog, fin;
      string p;
      p = $sformatf("v%0d_", n);
      clear_mem();
      fault_en   = v.fault;
      fault_addr = v.base + 8'd2;
      @(negedge clk);
      start     = 1'b1;
      base_addr = v.base;
      length    = v.len;
      idx = 0; wr = 0; bz = 0; rn = 0; webad = 0;
      xfer = 0; tog = 1; fin = 0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         @(negedge clk);
         start = (cyc == v.poke);
         if (start) begin
            base_addr = 8'd30;
            length    = 8'd4;
         end
         if (xfer) idx++;
         s_valid = (idx < int'(v.len)) && tog;
         s_data  = bval(idx);
         if (v.stall) tog = !tog;
         #1;
         xfer = s_valid && s_ready;
         if (mem_we !== xfer) webad++;
         if (mem_we) wr++;
         if (busy) bz++;
         if (run_pulse) rn++;
         fin = done || error;
      end
      s_valid = 1'b0;
      start   = 1'b0;
      chk({p, "finished"}, int'(fin), 1);
      repeat (2) begin
         @(negedge clk);
         #1;
         if (run_pulse) rn++;
      end
      chk({p, "done"}, int'(done), int'(v.e_done));
      chk({p, "error"}, int'(error), int'(v.e_err));
      chk({p, "err_code"}, int'(err_code), v.e_code);
      chk({p, "writes"}, wr, v.e_wr);
      chk({p, "busy_cycles"}, bz, v.e_busy);
      chk({p, "run_pulses"}, rn, v.e_run);
      chk({p, "we_gating"}, webad, 0);
      chk({p, "own_addr_idle"}, int'({mem_own, mem_addr}), 0);
      if (v.e_wr != 0) begin
         bad = 0;
         for (int k = 0; k < int'(v.len); k++)
            if (mem[int'(v.base) + k] !== bval(k)) bad++;
         chk({p, "mem_contents"}, bad, 0);
      end
      fault_en = 1'b0;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset_n   = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      length    = '0;
      s_valid   = 1'b0;
      s_data    = '0;
      clr_mem   = 1'b0;
      fault_en  = 1'b0;
      fault_addr = '0;

      //      base   len  stl flt poke dn er cd wr busy run
      tv[0] = '{8'h1C, 8'd4, 0, 0, -1, 1, 0, 0, 4, 9, 1};
      tv[1] = '{8'h1C, 8'd4, 1, 0, -1, 1, 0, 0, 4, 12, 1};
      tv[2] = '{8'h1C, 8'd4, 0, 1, -1, 0, 1, 2, 4, 9, 0};
      tv[3] = '{8'd30, 8'd4, 0, 0, -1, 0, 1, 1, 0, 0, 0};
      tv[4] = '{8'd0, 8'd0, 0, 0, -1, 1, 0, 0, 0, 0, 1};
      tv[5] = '{8'd0, 8'd16, 0, 0, 5, 1, 0, 0, 16, 33, 1};
      tv[6] = '{8'd0, 8'd32, 0, 0, -1, 1, 0, 0, 32, 65, 1};
      tv[7] = '{8'd31, 8'd1, 0, 0, -1, 1, 0, 0, 1, 3, 1};
      tv[8] = '{8'd32, 8'd0, 0, 0, -1, 1, 0, 0, 0, 0, 1};
      tv[9] = '{8'd33, 8'd0, 0, 0, -1, 0, 1, 1, 0, 0, 0};

      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs",
          int'({s_ready, mem_own, mem_we, mem_addr, mem_din,
                busy, done, error, err_code, run_pulse}), 0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(i, tv[i]);

      // Reset lands mid-write after two of eight bytes.
      clear_mem();
      @(negedge clk);
      start     = 1'b1;
      base_addr = 8'd0;
      length    = 8'd8;
      @(negedge clk);
      start   = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'hA9;
      @(negedge clk);
      s_data  = 8'h05;
      @(negedge clk);
      reset_n = 1'b0;
      s_valid = 1'b0;
      #1;
      chk("midload_reset_outputs",
          int'({s_ready, mem_own, mem_we, mem_addr, mem_din,
                busy, done, error, err_code, run_pulse}), 0);
      @(negedge clk);
      reset_n = 1'b1;
      chk("midload_mem0", int'(mem[0]), 'hA9);
      chk("midload_mem1", int'(mem[1]), 'h05);
      chk("midload_mem2", int'(mem[2]), 0);

      run_vec(10, tv[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Writer-side partner to the fetcher. While the core is held off, it owns the memory port and streams a program or data image into mem from a byte-wide valid/ready source.
- It then reads the written range back and checks it against a running checksum.
- On success it releases the memory port and pulses a run trigger that starts the fetcher.
- It replaces the bench-only manual_mem/addr_in/d_in muxing with synthesizable logic.

Parameters:
ADDR_WIDTH, `ADDR_WIDTH, memory address width
REG_WIDTH, `REG_WIDTH, data byte width (8)
DEPTH, 32, number of mem locations; legal addresses are 0..DEPTH-1
VERIFY, 1, 1 = perform readback checksum pass; 0 = skip it

Ports:
clk  in  1  system clock (phi2 domain); all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a load; sampled only in IDLE
base_addr  in  ADDR_WIDTH  first mem address to write; sampled on start
length  in  ADDR_WIDTH  byte count; sampled on start
s_valid  in  1  source byte valid
s_data  in  REG_WIDTH  source byte
s_ready  out  1  loader accepts byte; transfer = s_valid & s_ready
mem_own  out  1  loader owns mem port; drives external addr/din/we muxes
mem_we  out  1  mem write enable
mem_addr  out  ADDR_WIDTH  mem address
mem_din  out  REG_WIDTH  mem write data
mem_dout  in  REG_WIDTH  mem read data, registered, valid one clk after mem_addr
busy  out  1  high in WRITE and VERIFY
done  out  1  level; load succeeded; cleared by next accepted start
error  out  1  level; range or checksum failure; cleared by next accepted start
err_code  out  2  0 none, 1 range, 2 checksum
run_pulse  out  1  one-cycle trigger to the fetcher on entry to DONE

Behaviour:
- Reset (async): state IDLE. All outputs are 0: s_ready, mem_own, mem_we, mem_addr, mem_din, busy, done, error, err_code, run_pulse. Pointer, count and both checksums are cleared. Reset mid-load abandons the load immediately; mem contents already written stay as written.
- States: IDLE, WRITE, VERIFY, DONE, ERROR.
- IDLE: mem_own=0, s_ready=0. On start:
  - base_addr+length > DEPTH (computed ADDR_WIDTH+1 bits wide): go to ERROR, err_code=1.
  - length==0: go to DONE.
  - Otherwise: latch ptr=base_addr, cnt=length, wsum=0; clear done/error; go to WRITE.
- WRITE: mem_own=1, s_ready=1.
  - mem_we = s_valid, combinational, same cycle. mem_addr=ptr, mem_din=s_data.
  - On each transfer: ptr+1, cnt-1, wsum += s_data (mod 2^REG_WIDTH).
  - Stalls (s_valid=0) are unlimited; mem_we stays 0 while stalled.
  - On the transfer where cnt==1: next state is VERIFY (VERIFY=1) or DONE (VERIFY=0). ptr reloads base_addr and cnt reloads length.
- VERIFY: mem_own=1, s_ready=0, mem_we=0. Pipelined read, one address per cycle:
  - Cycles 0..length-1 issue mem_addr = base_addr+k.
  - Cycles 1..length accumulate rsum += mem_dout.
  - Total length+1 cycles.
  - In the final cycle: rsum==wsum goes to DONE; otherwise ERROR with err_code=2.
- DONE: mem_own=0, done=1, run_pulse=1 for exactly the first cycle. Stays until start.
- ERROR: mem_own=0, error=1, no run_pulse. Stays until start.
- start while busy is ignored.
- start in DONE/ERROR behaves as from IDLE.
- mem_addr returns to 0 whenever mem_own=0.
- ptr never wraps; the range check guarantees this.

Decomposition:
- Shared package pkg.v: state encodings LDR_IDLE..LDR_ERROR and err_code values LDR_ERR_NONE/RANGE/CSUM. ADDR_WIDTH/REG_WIDTH come from the existing macros.
- One sub-module: ldr_checksum. It holds an accumulator with clear/enable inputs, and is instantiated twice (wsum, rsum).

Test Plan:
- Load 4 bytes {A9,05,85,10} at base 0x1C, source valid every cycle, VERIFY=1 -> 4 writes to 0x1C..0x1F in 4 cycles, then 5 verify cycles. done=1, run_pulse high 1 cycle, mem_own falls, mem contents match.
- Same load with s_valid toggled 1,0,1,0 -> mem_we only on valid cycles, 4 writes total, result identical.
- Force a stuck bit on mem_dout during verify (0x85 reads 0x84) -> ERROR, err_code=2, no run_pulse.
- start with base_addr=30, length=4, DEPTH=32 -> ERROR next cycle, err_code=1, no mem_we ever asserted.
- length=0 -> DONE next cycle with run_pulse, no writes. A second start issued while busy in a 16-byte load is ignored.
- Assert reset_n low mid-WRITE after 2 of 8 bytes -> all outputs 0 immediately. A fresh start afterwards completes normally.
